// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Frame controller for the 2x2 pixel array. A start request runs one frame:
// erase, expose, convert (digital ramp driven onto the pixel buses), then two
// read phases. Each read phase captures one pixel pair into a valid/ready
// output stream. The array stays stalled until the consumer takes the word.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low reset
//   start      : frame request, honoured only while idle
//   expTime    : exposure length in cycles (0 behaves as 1), latched on start
//   busy       : high whenever a frame is in progress
//   frameDone  : one-cycle pulse in the first idle cycle after a frame
//   erase, expose, convert, read12, read34 : phase strobes to the array
//   adcDrive   : tri-state enable for the pixel buses, high only in convert
//   adcCount   : ramp code, counts 0 .. 2^PIX_W-1 during convert, else 0
//   pixIn1..4  : sampled pixel buses
//   outData    : captured pixel pair {pixInB, pixInA}
//   outValid   : outData holds a word not yet accepted
//   outReady   : consumer accepts when outValid && outReady
//
// All outputs are registered: the next-state logic computes every output for
// the coming cycle, so strobes change cleanly on the clock edge.
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int PIX_W        = 8,
  parameter int EXP_W        = 16,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_SETTLE  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W-1:0]     expTime,
  output logic                 busy,
  output logic                 frameDone,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic                 read12,
  output logic                 read34,
  output logic                 adcDrive,
  output logic [PIX_W-1:0]     adcCount,
  input  logic [PIX_W-1:0]     pixIn1,
  input  logic [PIX_W-1:0]     pixIn2,
  input  logic [PIX_W-1:0]     pixIn3,
  input  logic [PIX_W-1:0]     pixIn4,
  output logic [2*PIX_W-1:0]   outData,
  output logic                 outValid,
  input  logic                 outReady
);

  // One shared down-counter times erase, exposure and read settling, so it
  // must be wide enough for the largest of the three.
  localparam int ERASE_W  = $clog2(ERASE_CYCLES + 1);
  localparam int SETTLE_W = $clog2(READ_SETTLE + 1);
  localparam int CNT_W0   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;
  localparam int CNT_W    = (CNT_W0 > SETTLE_W) ? CNT_W0 : SETTLE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_RD12,
    S_OUT12,
    S_RD34,
    S_OUT34
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [PIX_W-1:0]     adc_count_q, adc_count_d;
  logic [2*PIX_W-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic                 erase_q, erase_d;
  logic                 expose_q, expose_d;
  logic                 convert_q, convert_d;
  logic                 read12_q, read12_d;
  logic                 read34_q, read34_d;
  logic                 adc_drive_q, adc_drive_d;

  logic                 xfer;

  // A word leaves the output register when the consumer is ready for it.
  assign xfer = out_valid_q && outReady;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    adc_count_d  = '0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          cnt_d   = CNT_W'(ERASE_CYCLES - 1);
          // A zero exposure still gives the array one expose cycle.
          exp_d   = (expTime == '0) ? EXP_W'(1) : expTime;
        end
      end

      S_ERASE: begin
        if (cnt_q == '0) begin
          state_d = S_EXPOSE;
          // exp_q is never zero, so exp_q-1 cannot underflow; a full-scale
          // exposure fits because the counter counts down from exp_q-1.
          cnt_d   = CNT_W'(exp_q) - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_EXPOSE: begin
        // adc_count_d defaults to 0, which is the first ramp code.
        if (cnt_q == '0) begin
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_CONVERT: begin
        // The ramp ends at full scale and never wraps; leaving convert
        // returns adcCount to 0 through the default above.
        if (adc_count_q == '1) begin
          state_d = S_RD12;
          cnt_d   = CNT_W'(READ_SETTLE - 1);
        end else begin
          adc_count_d = adc_count_q + PIX_W'(1);
        end
      end

      S_RD12: begin
        if (cnt_q == '0) begin
          state_d     = S_OUT12;
          out_data_d  = {pixIn2, pixIn1};
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_OUT12: begin
        if (xfer) begin
          state_d     = S_RD34;
          out_valid_d = 1'b0;
          cnt_d       = CNT_W'(READ_SETTLE - 1);
        end
      end

      S_RD34: begin
        if (cnt_q == '0) begin
          state_d     = S_OUT34;
          out_data_d  = {pixIn4, pixIn3};
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_OUT34: begin
        if (xfer) begin
          state_d      = S_IDLE;
          out_valid_d  = 1'b0;
          frame_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes follow the state being entered, so each one is a clean
    // registered level with no overlap between phases.
    busy_d      = (state_d != S_IDLE);
    erase_d     = (state_d == S_ERASE);
    expose_d    = (state_d == S_EXPOSE);
    convert_d   = (state_d == S_CONVERT);
    read12_d    = (state_d == S_RD12);
    read34_d    = (state_d == S_RD34);
    adc_drive_d = (state_d == S_CONVERT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // A pending output word is discarded along with the frame.
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      adc_count_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read12_q     <= 1'b0;
      read34_q     <= 1'b0;
      adc_drive_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      adc_count_q  <= adc_count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      read12_q     <= read12_d;
      read34_q     <= read34_d;
      adc_drive_q  <= adc_drive_d;
    end
  end

  assign busy      = busy_q;
  assign frameDone = frame_done_q;
  assign erase     = erase_q;
  assign expose    = expose_q;
  assign convert   = convert_q;
  assign read12    = read12_q;
  assign read34    = read34_q;
  assign adcDrive  = adc_drive_q;
  assign adcCount  = adc_count_q;
  assign outData   = out_data_q;
  assign outValid  = out_valid_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed bench for frame_sequencer. A frame-schedule model (phase windows
// computed from the frame offset, exposure and accumulated stall cycles) is
// compared with the DUT on every cycle; literal checks at hand-computed
// cycles pin the model to the expected timeline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_sequencer;
  localparam int PIX_W        = 8;
  localparam int EXP_W        = 16;
  localparam int ERASE_CYCLES = 5;
  localparam int READ_SETTLE  = 2;
  localparam int NCONV        = 1 << PIX_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [EXP_W-1:0]     expTime;
  logic                 busy, frameDone, erase, expose, convert;
  logic                 read12, read34, adcDrive, outValid;
  logic [PIX_W-1:0]     adcCount;
  logic [PIX_W-1:0]     pixIn1, pixIn2, pixIn3, pixIn4;
  logic [2*PIX_W-1:0]   outData;
  logic                 outReady;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;
  bit  rand_pix = 1'b0;
  bit  stim_done = 1'b0;

  frame_sequencer #(
    .PIX_W(PIX_W), .EXP_W(EXP_W),
    .ERASE_CYCLES(ERASE_CYCLES), .READ_SETTLE(READ_SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expTime(expTime),
    .busy(busy), .frameDone(frameDone), .erase(erase), .expose(expose),
    .convert(convert), .read12(read12), .read34(read34), .adcDrive(adcDrive),
    .adcCount(adcCount), .pixIn1(pixIn1), .pixIn2(pixIn2), .pixIn3(pixIn3),
    .pixIn4(pixIn4), .outData(outData), .outValid(outValid), .outReady(outReady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel buses: fixed pattern, or fresh random values every cycle so that
  // the capture instant is pinned exactly.
  always @(negedge clk) begin
    if (rand_pix) begin
      pixIn1 <= PIX_W'($urandom);
      pixIn2 <= PIX_W'($urandom);
      pixIn3 <= PIX_W'($urandom);
      pixIn4 <= PIX_W'($urandom);
    end else begin
      pixIn1 <= 8'h11;
      pixIn2 <= 8'h22;
      pixIn3 <= 8'h33;
      pixIn4 <= 8'h44;
    end
  end

  // ---------------- frame-schedule model ----------------
  // m_t counts cycles since the frame began (0 = first busy cycle).
  bit                 m_act = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_t = 0, m_e = 1, m_s12 = 0, m_s34 = 0;
  logic [2*PIX_W-1:0] m_cap = '0;
  int                 b_x, b_c, b_o1, b_r2, b_o2, b_e2;

  // Phase window starts: expose at ERASE_CYCLES, convert at b_x, read12 at
  // b_c, OUT12 at b_o1 (1 + stall cycles long), read34 at b_r2, OUT34 at b_o2.
  always_comb begin
    b_x  = ERASE_CYCLES + m_e;
    b_c  = b_x + NCONV;
    b_o1 = b_c + READ_SETTLE;
    b_r2 = b_o1 + 1 + m_s12;
    b_o2 = b_r2 + READ_SETTLE;
    b_e2 = b_o2 + 1 + m_s34;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_cap  <= '0;
    end else if (!m_act) begin
      m_done <= 1'b0;
      if (start) begin
        m_act <= 1'b1;
        m_t   <= 0;
        m_e   <= (expTime == '0) ? 1 : int'(expTime);
        m_s12 <= 0;
        m_s34 <= 0;
      end
    end else begin
      if (m_t == b_o1 - 1) m_cap <= {pixIn2, pixIn1};
      if (m_t == b_o2 - 1) m_cap <= {pixIn4, pixIn3};
      if (m_t >= b_o1 && m_t < b_r2 && !outReady) m_s12 <= m_s12 + 1;
      if (m_t >= b_o2 && m_t < b_e2) begin
        if (!outReady) m_s34 <= m_s34 + 1;
        else begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end
      end
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic cv, vld;
    logic [PIX_W-1:0] adc;
    cv  = m_act && m_t >= b_x && m_t < b_c;
    vld = m_act && ((m_t >= b_o1 && m_t < b_r2) || (m_t >= b_o2 && m_t < b_e2));
    adc = cv ? PIX_W'(m_t - b_x) : '0;
    check("flags", 64'({busy, frameDone, erase, expose, convert, read12, read34, adcDrive, outValid}),
          64'({m_act, m_done,
               m_act && m_t < ERASE_CYCLES,
               m_act && m_t >= ERASE_CYCLES && m_t < b_x,
               cv,
               m_act && m_t >= b_c && m_t < b_o1,
               m_act && m_t >= b_r2 && m_t < b_o2,
               cv, vld}));
    check("adcCount", 64'(adcCount), 64'(adc));
    check("outData", 64'(outData), 64'(m_cap));
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({busy, frameDone, erase, expose, convert, read12, read34,
                adcDrive, outValid, adcCount, outData});
  endfunction

  int base;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    outReady = 1'b1;
    expTime  = '0;
    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (chk_en) compare_cycle();
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", all_out(), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Frame 1: defaults, exp 10, fixed pixels, stray start while busy.
        base = cyc;
        check("idle_busy", 64'(busy), 64'd0);
        expTime = 16'd10;
        start   = 1'b1;
        wait_until(base + 1);
        start = 1'b0;
        check("f1_erase_c1", 64'({erase, busy}), 64'b11);
        wait_until(base + 3);
        start = 1'b1;
        expTime = 16'd40;
        wait_until(base + 4);
        start = 1'b0;
        wait_until(base + 5);
        check("f1_erase_c5", 64'(erase), 64'd1);
        wait_until(base + 6);
        check("f1_expose_c6", 64'({expose, erase}), 64'b10);
        wait_until(base + 15);
        check("f1_expose_c15", 64'(expose), 64'd1);
        wait_until(base + 16);
        check("f1_convert_c16", 64'({convert, adcDrive, adcCount}), 64'h300);
        wait_until(base + 271);
        check("f1_convert_c271", 64'({convert, adcCount}), 64'h1ff);
        wait_until(base + 272);
        check("f1_read12_c272", 64'({read12, adcDrive, adcCount}), 64'h200);
        wait_until(base + 274);
        check("f1_out12_c274", 64'({outValid, read12, outData}), 64'h2_2211);
        wait_until(base + 275);
        check("f1_read34_c275", 64'({read34, outValid}), 64'b10);
        wait_until(base + 277);
        check("f1_out34_c277", 64'({outValid, outData}), 64'h1_4433);
        wait_until(base + 278);
        check("f1_done_c278", 64'({frameDone, busy}), 64'b10);
        wait_until(base + 279);
        check("f1_done_c279", 64'(frameDone), 64'd0);

        // Frame 2: exp 0, random pixels, 7-cycle stall in OUT12, start held
        // high across frameDone.
        wait_until(base + 281);
        base = cyc;
        rand_pix = 1'b1;
        expTime  = 16'd0;
        start    = 1'b1;
        wait_until(base + 1);
        start = 1'b0;
        wait_until(base + 6);
        check("f2_expose_c6", 64'(expose), 64'd1);
        wait_until(base + 7);
        check("f2_convert_c7", 64'({expose, convert}), 64'b01);
        wait_until(base + 265);
        check("f2_out12_c265", 64'(outValid), 64'd1);
        outReady = 1'b0;
        wait_until(base + 270);
        check("f2_stall_c270", 64'({outValid, read12, read34, erase, expose, convert}), 64'b100000);
        wait_until(base + 271);
        start   = 1'b1;
        expTime = 16'd3;
        wait_until(base + 272);
        check("f2_stall_c272", 64'({outValid, read34}), 64'b10);
        outReady = 1'b1;
        wait_until(base + 273);
        check("f2_read34_c273", 64'({read34, outValid}), 64'b10);
        wait_until(base + 276);
        check("f2_done_c276", 64'({frameDone, busy}), 64'b10);
        wait_until(base + 277);
        check("f3_erase_c277", 64'({erase, busy, frameDone}), 64'b110);
        start = 1'b0;

        // Frame 3: reset in convert.
        base = base + 276;
        wait_until(base + 50);
        check("f3_convert_c50", 64'({convert, adcCount}), 64'h129);
        reset = 1'b0;
        wait_until(base + 51);
        check("f3_reset_c51", all_out(), 64'd0);
        reset = 1'b1;
        wait_until(base + 52);
        check("f3_after_c52", 64'({busy, frameDone}), 64'd0);

        // Frame 4: reset in OUT34 with a pending word.
        wait_until(base + 53);
        base = cyc;
        expTime = 16'd2;
        start   = 1'b1;
        wait_until(base + 1);
        start = 1'b0;
        wait_until(base + 267);
        outReady = 1'b0;
        wait_until(base + 269);
        check("f4_out34_c269", 64'(outValid), 64'd1);
        wait_until(base + 272);
        check("f4_hold_c272", 64'({outValid, busy}), 64'b11);
        reset = 1'b0;
        wait_until(base + 273);
        check("f4_reset_c273", all_out(), 64'd0);
        reset    = 1'b1;
        outReady = 1'b1;
        wait_until(base + 274);
        check("f4_after_c274", 64'({busy, frameDone, outValid}), 64'd0);

        // Frame 5: full frame after reset, exp 4.
        base = cyc;
        expTime = 16'd4;
        start   = 1'b1;
        wait_until(base + 1);
        start = 1'b0;
        wait_until(base + 271);
        check("f5_out34_c271", 64'({outValid, busy}), 64'b11);
        wait_until(base + 272);
        check("f5_done_c272", 64'({frameDone, busy}), 64'b10);
        wait_until(base + 275);
        stim_done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Configurable frame controller for the 2x2 pixel array. On a start request it sequences the array through erase, expose, convert and two read phases. During convert it drives a digital ramp count onto the pixel data buses. During the read phases it captures pixel data into a valid/ready output stream, stalling the array until the consumer accepts each word. It sits beside the array at top level and owns every phase strobe plus the pixel-bus drive enable.

## Interface
Parameters:
- PIX_W, 8, pixel/ADC code width; a conversion lasts 2^PIX_W cycles
- EXP_W, 16, width of exposure-time input
- ERASE_CYCLES, 5, cycles erase is held (>=1)
- READ_SETTLE, 2, cycles a read strobe is held before capture (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  frame request, sampled in IDLE only
- expTime  in  EXP_W  exposure length in cycles, latched when start is accepted
- busy  out  1  high whenever state != IDLE
- frameDone  out  1  one-cycle pulse on frame completion
- erase, expose, convert, read12, read34  out  1 each  phase strobes to the array
- adcDrive  out  1  tri-state enable for the pixData buses, high only in CONVERT
- adcCount  out  PIX_W  ramp code for the pixel buses
- pixIn1, pixIn2, pixIn3, pixIn4  in  PIX_W each  sampled pixData buses
- outData  out  2*PIX_W  captured pixel pair, {pixInB, pixInA}
- outValid  out  1  outData holds an unaccepted word
- outReady  in  1  consumer accepts when outValid && outReady

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, RD12, OUT12, RD34, OUT34.
- IDLE, start=1: latch expTime (0 treated as 1) and go to ERASE. start while busy is ignored, not queued.
- ERASE: erase=1 for ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for the latched exposure count, then CONVERT.
- CONVERT:
  - convert=1 and adcDrive=1.
  - adcCount is 0 in the first cycle and increments by 1 per cycle to 2^PIX_W-1 in the last cycle. No wrap.
  - Go to RD12.
  - adcCount is 0 in every other state.
- RD12:
  - read12=1 for READ_SETTLE cycles.
  - On the edge ending the last cycle, capture outData={pixIn2,pixIn1} and go to OUT12.
- OUT12:
  - All strobes low, outValid=1.
  - outData is held stable until the transfer.
  - On transfer, go to RD34 next cycle with outValid=0.
- RD34/OUT34: same as RD12/OUT12, using read34 and outData={pixIn4,pixIn3}.
- OUT34 transfer: go to IDLE and pulse frameDone for that first IDLE cycle (busy=0 in that cycle).
- Strobes (erase, expose, convert, read12, read34) are mutually exclusive. adcDrive never overlaps a read strobe.
- outValid never drops without a transfer, except on reset.

## Timing
- Reset (reset=0 at an edge):
  - Next cycle: state IDLE.
  - All outputs 0: strobes, adcDrive, adcCount, outData, outValid, busy, frameDone.
  - Applies mid-frame, including a pending outValid word, which is discarded.
- Start latency: start high at edge N puts erase high in cycle N+1.
- Frame length with outReady tied high: ERASE_CYCLES + exp + 2^PIX_W + 2*(READ_SETTLE+1) cycles of busy.
  - frameDone follows in the next cycle.
- Each outValid costs at least 1 cycle; each cycle outReady is low extends OUT12/OUT34 by one cycle.
- start in the frameDone cycle is accepted (state is IDLE).
- A counter may reach the latched exp value of up to 2^EXP_W-1 without overflow.

## Test plan
- Defaults, expTime=10, start pulse at cycle 0, outReady=1:
  - erase in cycles 1-5, expose 6-15, convert 16-271 (adcCount 0 at 16, 255 at 271).
  - read12 272-273, outValid 274.
  - read34 275-276, outValid 277.
  - frameDone 278.
- pixIn1..4 = 0x11, 0x22, 0x33, 0x44 during reads -> outData 0x2211, then 0x4433.
- outReady low for 7 cycles in OUT12 -> outValid and outData held for 8 cycles, read34 delayed by 7 cycles, no strobe high meanwhile.
- expTime=0 -> expose high exactly 1 cycle.
- start pulsed while busy -> ignored.
- start held high across frameDone -> second frame starts the cycle after frameDone.
- reset=0 during CONVERT, and separately during OUT34 with outReady=0 -> all outputs 0 next cycle, busy=0, no frameDone, new start runs a full frame.
